// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end of the shifting-LED block.
// Mode encodings are the one-hot patterns that drive the LED block's `but` input.
package btn_pkg;

  localparam int N_BTN_DEF    = 4;
  localparam int DEBOUNCE_DEF = 1_000_000;

  localparam logic [3:0] MODE_NONE = 4'b0000;
  localparam logic [3:0] MODE_B0   = 4'b0001;
  localparam logic [3:0] MODE_B1   = 4'b0010;
  localparam logic [3:0] MODE_B2   = 4'b0100;
  localparam logic [3:0] MODE_B3   = 4'b1000;

endpackage

// File: rtl/debounce_bit.sv
// One button: 2-flop synchroniser, stability counter, stable level and rising-edge pulse.
// Raw edge sampled at edge k shows on stable/rise at edge k+1+DEBOUNCE_CYCLES; no backpressure.
module debounce_bit
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic rise_next
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Terminal compare is checked before the increment, so cnt never wraps.
  assign accept    = (s2 != stable) && (cnt == CNT_LAST);
  assign rise_next = accept && s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= rise_next;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounced buttons -> press pulses -> latched one-hot mode (lowest index wins on ties).
// btn_press and but_mode update on the same edge as btn_stable rises; no backpressure.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] but_mode,
  output logic             mode_valid
);

  logic [N_BTN-1:0] press_next;
  logic [N_BTN-1:0] press_pick;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .raw      (btn_raw[i]),
      .stable   (btn_stable[i]),
      .rise     (btn_press[i]),
      .rise_next(press_next[i])
    );
  end

  // Two's-complement trick isolates the lowest set bit, guaranteeing one-hot.
  assign press_pick = press_next & (~press_next + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      but_mode   <= '0;
      mode_valid <= 1'b0;
    end else if (|press_next) begin
      but_mode   <= press_pick;
      mode_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4: row table plus hand sequences,
// press pulses checked against a timed scoreboard queue, invariants checked every cycle.
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int NB  = 4;
  localparam int DB  = 4;
  localparam int LAT = DB + 2; // drive at cycle n -> press visible at cycle n+LAT

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_stable;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] but_mode;
  logic          mode_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [NB-1:0] prev_press = '0;

  typedef struct {
    int            cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] mode;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] press;
    logic [NB-1:0] stable;
    logic [NB-1:0] mode;
  } vec_t;
  vec_t tbl[11];

  button_conditioner #(
    .N_BTN(NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_stable(btn_stable),
    .btn_press (btn_press),
    .but_mode  (but_mode),
    .mode_valid(mode_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic expect_press(input logic [NB-1:0] p, input logic [NB-1:0] m);
    exp_t e;
    e.cyc   = cyc + LAT;
    e.press = p;
    e.mode  = m;
    sb.push_back(e);
  endtask

  // Per-cycle monitor: reset state, invariants, and scoreboard for press pulses.
  always @(negedge clk) begin
    exp_t e;
    if (rst)
      chk("rst_outputs", {19'd0, btn_stable, btn_press, but_mode, mode_valid}, 32'd0);
    chk("mode_onehot", 32'(but_mode & (but_mode - 1'b1)), 32'd0);
    chk("press_2cyc", 32'(btn_press & prev_press), 32'd0);
    prev_press = btn_press;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL press_missing at cyc %0d: got none want %b due cyc %0d", cyc, e.press, e.cyc);
    end
    if (btn_press != '0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL press_unexpected at cyc %0d: got %b want none", cyc, btn_press);
      end else begin
        e = sb.pop_front();
        chk("press_cycle", 32'(cyc), 32'(e.cyc));
        chk("press_value", 32'(btn_press), 32'(e.press));
        chk("press_mode", 32'(but_mode), 32'(e.mode));
        chk("press_valid", 32'(mode_valid), 32'd1);
      end
    end
  end

  task automatic bounce_seq();
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = (i % 2 == 0);
      repeat (2) step();
    end
    btn_raw[1] = 1'b1;
    expect_press(4'b0010, MODE_B1);
    repeat (8) step();
    chk("bounce_stable", 32'(btn_stable), 32'(4'b0010));
    chk("bounce_mode", 32'(but_mode), 32'(MODE_B1));
  endtask

  task automatic reset_seq();
    btn_raw = 4'b1000;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("async_clear", {19'd0, btn_stable, btn_press, but_mode, mode_valid}, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    expect_press(4'b1000, MODE_B3);
    repeat (8) step();
    chk("rstmid_stable", 32'(btn_stable), 32'(4'b1000));
    chk("rstmid_mode", 32'(but_mode), 32'(MODE_B3));
    chk("rstmid_valid", 32'(mode_valid), 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 4'b1111;
    //           raw      press    stable   mode
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, MODE_B0};
    tbl[1]  = '{4'b0001, 4'b0001, 4'b0001, MODE_B0};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, MODE_B0};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, MODE_B1};
    tbl[4]  = '{4'b1100, 4'b1100, 4'b1100, MODE_B2};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, MODE_B2};
    tbl[6]  = '{4'b0110, 4'b0110, 4'b0110, MODE_B1};
    tbl[7]  = '{4'b0111, 4'b0001, 4'b0111, MODE_B0};
    tbl[8]  = '{4'b0111, 4'b0000, 4'b0111, MODE_B0};
    tbl[9]  = '{4'b0100, 4'b0000, 4'b0100, MODE_B0};
    tbl[10] = '{4'b0101, 4'b0001, 4'b0101, MODE_B0};

    // All buttons held through reset: fresh press one full debounce after release.
    repeat (10) step();
    chk("rst_mode", 32'(but_mode), 32'(MODE_NONE));
    rst = 1'b0;
    expect_press(4'b1111, MODE_B0);
    repeat (8) step();
    chk("init_stable", 32'(btn_stable), 32'(4'b1111));
    chk("init_mode", 32'(but_mode), 32'(MODE_B0));
    chk("init_valid", 32'(mode_valid), 32'd1);

    for (int i = 0; i < 11; i++) begin
      if (i == 3) bounce_seq();
      if (i == 6) reset_seq();
      btn_raw = tbl[i].raw;
      if (tbl[i].press != '0) expect_press(tbl[i].press, tbl[i].mode);
      repeat (8) step();
      chk($sformatf("row%0d_stable", i), 32'(btn_stable), 32'(tbl[i].stable));
      chk($sformatf("row%0d_mode", i), 32'(but_mode), 32'(tbl[i].mode));
      chk($sformatf("row%0d_valid", i), 32'(mode_valid), 32'd1);
    end

    repeat (2) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
